// File: rtl/tff_pkg.sv
// Shared definitions for the T-flip-flop counter library: direction encoding
// and the legal parameter limits checked at elaboration.
package tff_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int unsigned MAX_WIDTH   = 16;
  localparam int unsigned MIN_MODULUS = 2;

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// Single T flip-flop cell with synchronous reset, parallel load and an
// independently registered complement output.
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic t,
  input  logic ld,
  input  logic ld_val,
  output logic q,
  output logic qbar
);

  // NOTE: sequential state uses non-blocking assignments so every cell samples
  // the pre-edge values of the shared next-state logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= rst_val;
      qbar <= ~rst_val;
    end else if (ld) begin
      q    <= ld_val;
      qbar <= ~ld_val;
    end else if (t) begin
      q    <= ~q;
      qbar <= ~qbar;
    end
  end

endmodule : tff_cell

// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH T cells, with load, terminal
// count and wrap pulse. Define TFF_CNT_DIVOUT_EN to add the div_out divider.
module tff_mod_counter
  import tff_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 10,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
`ifdef TFF_CNT_DIVOUT_EN
  output logic             div_out,
`endif
  output logic             wrap
);

  generate
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("tff_mod_counter: WIDTH must be 1..16");
    end
    if (MODULUS < MIN_MODULUS || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("tff_mod_counter: MODULUS must be 2..2**WIDTH");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
      $error("tff_mod_counter: RESET_VAL must be below MODULUS");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  dir_e             dir;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] ld_q;
  logic             wrap_evt;

  assign dir = dir_e'(up);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nxt = q;
    if (dir == DIR_UP) begin
      nxt = (q == MAX_Q) ? '0 : q + WIDTH'(1);
    end else begin
      nxt = (q == '0) ? MAX_Q : q - WIDTH'(1);
    end
  end

  // Each cell toggles exactly where the current and next counts differ.
  assign t    = en ? (q ^ nxt) : '0;
  assign ld_q = (load_val > MAX_Q) ? MAX_Q : load_val;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell u_cell (
        .clk     (clk),
        .reset   (reset),
        .rst_val (RST_Q[i]),
        .t       (t[i]),
        .ld      (load),
        .ld_val  (ld_q[i]),
        .q       (q[i]),
        .qbar    (qbar[i])
      );
    end
  endgenerate

  assign tc       = (dir == DIR_UP) ? (q == MAX_Q) : (q == '0);
  assign wrap_evt = en & ~load & tc;

  always_ff @(posedge clk) begin
    if (reset) wrap <= 1'b0;
    else       wrap <= wrap_evt;
  end

`ifdef TFF_CNT_DIVOUT_EN
  always_ff @(posedge clk) begin
    if (reset)         div_out <= 1'b0;
    else if (wrap_evt) div_out <= ~div_out;
  end
`endif

endmodule : tff_mod_counter

// File: tb/tb_tff_mod_counter.sv
// Directed self-checking bench for tff_mod_counter (WIDTH=4, MODULUS=10).
module tb_tff_mod_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, load;
  logic [3:0] load_val;
  logic [3:0] q, qbar;
  logic       tc, wrap;
`ifdef TFF_CNT_DIVOUT_EN
  logic       div_out;
`endif

  int checks   = 0;
  int failures = 0;

  tff_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .qbar     (qbar),
    .tc       (tc),
`ifdef TFF_CNT_DIVOUT_EN
    .div_out  (div_out),
`endif
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks q, qbar, wrap and tc (derived from the expected q and current up).
  task automatic expect_state(input string tag, input logic [3:0] eq, input logic ew);
    logic etc;
    etc = up ? (eq == 4'd9) : (eq == 4'd0);
    check({tag, ".q"},    {28'd0, q},    {28'd0, eq});
    check({tag, ".qbar"}, {28'd0, qbar}, {28'd0, ~eq});
    check({tag, ".wrap"}, {31'd0, wrap}, {31'd0, ew});
    check({tag, ".tc"},   {31'd0, tc},   {31'd0, etc});
  endtask

  int exp_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_dn [3]  = '{0, 9, 8};
  int exp_dnw[3]  = '{0, 1, 0};
  int exp_dir[4]  = '{5, 4, 5, 4};

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
    step();
    step();
    reset = 1'b0;
    expect_state("reset", 4'd0, 1'b0);

    // Up count through one wrap.
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      expect_state($sformatf("up%0d", i), 4'(exp_up[i]), (i == 9));
    end

    // Load 1, then count down through 0.
    en = 1'b0; up = 1'b0; load = 1'b1; load_val = 4'd1;
    step();
    expect_state("dn_load", 4'd1, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_state($sformatf("dn%0d", i), 4'(exp_dn[i]), exp_dnw[i][0]);
    end

    // Clamp of an out-of-range load; load must suppress wrap even with tc high.
    load = 1'b1; en = 1'b1; load_val = 4'd13; up = 1'b0;
    step();
    expect_state("clamp", 4'd9, 1'b0);
    up = 1'b1;
    #1;
    check("clamp.tc_pre", {31'd0, tc}, 32'd1);
    step();
    expect_state("load_nowrap", 4'd9, 1'b0);

    // Reset beats a pending wrap event, then beats load.
    load = 1'b0; reset = 1'b1;
    step();
    expect_state("rst_wrap", 4'd0, 1'b0);
    load = 1'b1; load_val = 4'd5;
    step();
    expect_state("rst_load", 4'd0, 1'b0);
    reset = 1'b0;

    // Hold at 4, then alternate direction every cycle.
    load_val = 4'd4;
    step();
    expect_state("ld4", 4'd4, 1'b0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_state($sformatf("hold%0d", i), 4'd4, 1'b0);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = (i % 2 == 0);
      step();
      expect_state($sformatf("dir%0d", i), 4'(exp_dir[i]), 1'b0);
    end

`ifdef TFF_CNT_DIVOUT_EN
    reset = 1'b1; en = 1'b0; up = 1'b1;
    step();
    check("div.reset", {31'd0, div_out}, 32'd0);
    reset = 1'b0; en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      check($sformatf("div%0d", k), {31'd0, div_out}, ((k / 10) % 2));
    end
    // A load at the terminal count must leave div_out alone.
    load = 1'b1; load_val = 4'd9;
    step();
    step();
    check("div.load", {31'd0, div_out}, 32'd0);
    load = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tff_mod_counter
